// File: rtl/usr_pkg.sv
// Shared mode codes, FSM state encoding and mode classification for the universal shift register.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Shift/rotate modes are the ones that honour shamt and may run multi-cycle.
  function automatic logic is_shift(input logic [2:0] m);
    return (m != MODE_HOLD) && (m != MODE_LOAD) && (m != MODE_CLEAR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// One-position next-value function of the shift register; purely combinational.
// LOAD is resolved by the caller since parallel data is not an input here.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [2:0]       i_mode,
  input  logic             i_ser_in_lsb,
  input  logic             i_ser_in_msb,
  output logic [WIDTH-1:0] o_q_next
);

  always_comb begin
    o_q_next = i_q;
    case (i_mode)
      MODE_SHL:   o_q_next = {i_q[WIDTH-2:0], i_ser_in_lsb};
      MODE_SHR:   o_q_next = {i_ser_in_msb, i_q[WIDTH-1:1]};
      MODE_ROL:   o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      MODE_ROR:   o_q_next = {i_q[0], i_q[WIDTH-1:1]};
      MODE_ASR:   o_q_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
      MODE_CLEAR: o_q_next = '0;
      default:    o_q_next = i_q;
    endcase
  end

endmodule

// File: rtl/usr_shift_reg.sv
// Universal shift register: single-cycle HOLD/LOAD/CLEAR, N-step shifts/rotates via a RUN state.
// Start-to-done latency is 1 edge for single-cycle ops and N+1 edges for N-step shifts; start is ignored while busy.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] shamt,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [2:0]       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_step_mode;
  logic [WIDTH-1:0] w_q_next;

  // The same step function serves the start edge (live mode) and each RUN step (latched mode).
  assign w_step_mode = (r_state == ST_RUN) ? r_mode : mode;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .i_q          (r_q),
    .i_mode       (w_step_mode),
    .i_ser_in_lsb (ser_in_lsb),
    .i_ser_in_msb (ser_in_msb),
    .o_q_next     (w_q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (!is_shift(mode)) begin
              r_q    <= (mode == MODE_LOAD) ? par_in : w_q_next;
              r_done <= 1'b1;
            end else if (shamt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_mode  <= mode;
              r_cnt   <= shamt;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign q           = r_q;
  assign ser_out_msb = r_q[WIDTH-1];
  assign ser_out_lsb = r_q[0];
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_usr_shift_reg.sv
// Randomized and directed bench for usr_shift_reg (WIDTH=8) against an arithmetic operation-level model.
module tb_usr_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] par_in;
  logic             ser_in_lsb;
  logic             ser_in_msb;
  logic [WIDTH-1:0] q;
  logic             ser_out_msb;
  logic             ser_out_lsb;
  logic             busy;
  logic             done;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: register value, steps still owed, latched op, done flag.
  int         m_q;
  int         m_left;
  logic [2:0] m_mode;
  logic       m_done;

  usr_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .shamt       (shamt),
    .par_in      (par_in),
    .ser_in_lsb  (ser_in_lsb),
    .ser_in_msb  (ser_in_msb),
    .q           (q),
    .ser_out_msb (ser_out_msb),
    .ser_out_lsb (ser_out_lsb),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One-position move expressed as integer arithmetic on an 8-bit value.
  function automatic int mstep(input logic [2:0] md, input int v, input int li, input int mi);
    case (md)
      3'd2:    return (v * 2 + li) % 256;
      3'd3:    return v / 2 + mi * 128;
      3'd4:    return (v * 2) % 256 + v / 128;
      3'd5:    return v / 2 + (v % 2) * 128;
      3'd6:    return v / 2 + (v / 128) * 128;
      default: return v;
    endcase
  endfunction

  // Advance model with the inputs present at this edge, then compare after the edge.
  task automatic tick();
    int nq, nleft;
    logic nd;
    logic [2:0] nmode;
    nq = m_q; nleft = m_left; nd = 1'b0; nmode = m_mode;
    if (rst) begin
      nq = 0; nleft = 0; nmode = 3'd0;
    end else if (m_left > 0) begin
      nq = mstep(m_mode, m_q, int'(ser_in_lsb), int'(ser_in_msb));
      nleft = m_left - 1;
      nd = (nleft == 0);
    end else if (start) begin
      if (mode == 3'd1)      begin nq = int'(par_in); nd = 1'b1; end
      else if (mode == 3'd7) begin nq = 0;            nd = 1'b1; end
      else if (mode == 3'd0 || shamt == 0) nd = 1'b1;
      else begin nleft = int'(shamt); nmode = mode; end
    end
    @(posedge clk);
    #1;
    m_q = nq; m_left = nleft; m_done = nd; m_mode = nmode;
    check("q",       q,           8'(m_q));
    check("busy",    {7'd0, busy},        {7'd0, m_left > 0});
    check("done",    {7'd0, done},        {7'd0, m_done});
    check("ser_msb", {7'd0, ser_out_msb}, {7'd0, 1'(m_q / 128)});
    check("ser_lsb", {7'd0, ser_out_lsb}, {7'd0, 1'(m_q % 2)});
  endtask

  task automatic run_op(input logic [2:0] md, input logic [3:0] n, input logic [7:0] pin);
    start = 1'b1; mode = md; shamt = n; par_in = pin;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(n); i++) tick();
  endtask

  initial begin
    m_q = 0; m_left = 0; m_mode = 3'd0; m_done = 1'b0;
    rst = 1'b1; start = 1'b1; mode = 3'($urandom); shamt = 4'($urandom);
    par_in = 8'($urandom); ser_in_lsb = 1'($urandom); ser_in_msb = 1'($urandom);

    // Reset dominates even with start asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_q", q, 8'h00);
    end
    rst = 1'b0; start = 1'b0;
    tick(); tick();
    check("idle_q", q, 8'h00);

    // LOAD then SHL 3 with lsb fill of 1.
    ser_in_lsb = 1'b1;
    run_op(3'd1, 4'd0, 8'hA5);
    check("load_q", q, 8'hA5);
    check("load_done", {7'd0, done}, 8'd1);
    start = 1'b1; mode = 3'd2; shamt = 4'd3;
    tick(); start = 1'b0;
    check("shl_busy", {7'd0, busy}, 8'd1);
    tick(); check("shl_e1", q, 8'h4B);
    tick(); check("shl_e2", q, 8'h97);
    tick(); check("shl_e3", q, 8'h2F);
    check("shl_done", {7'd0, done}, 8'd1);
    check("shl_msb", {7'd0, ser_out_msb}, 8'd0);
    tick();

    // Rotates, including a count larger than WIDTH.
    run_op(3'd1, 4'd0, 8'hA5);
    run_op(3'd5, 4'd4, 8'h00);
    check("ror4", q, 8'h5A);
    check("ror4_done", {7'd0, done}, 8'd1);
    run_op(3'd4, 4'd9, 8'h00);
    check("rol9", q, 8'hB4);

    // ASR replicates MSB; SHR takes a live serial stream per step.
    run_op(3'd1, 4'd0, 8'h80);
    run_op(3'd6, 4'd2, 8'h00);
    check("asr2", q, 8'hE0);
    run_op(3'd6, 4'd12, 8'h00);
    check("asr_sat", q, 8'hFF);
    run_op(3'd1, 4'd0, 8'h80);
    start = 1'b1; mode = 3'd3; shamt = 4'd2; tick(); start = 1'b0;
    ser_in_msb = 1'b1; tick(); check("shr_e1", q, 8'hC0);
    ser_in_msb = 1'b0; tick(); check("shr_e2", q, 8'h60);

    // A start pulse during RUN is ignored.
    ser_in_lsb = 1'b0;
    run_op(3'd1, 4'd0, 8'h3C);
    start = 1'b1; mode = 3'd2; shamt = 4'd8; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; mode = 3'd1; par_in = 8'hFF; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ign_q", q, 8'h00);
    check("ign_done", {7'd0, done}, 8'd1);

    // Reset mid-RUN discards the operation with no done pulse.
    run_op(3'd1, 4'd0, 8'h5A);
    start = 1'b1; mode = 3'd4; shamt = 4'd5; tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_run_busy", {7'd0, busy}, 8'd0);
    tick(); tick();
    check("rst_run_done", {7'd0, done}, 8'd0);

    // shamt=0 completes in one cycle; CLEAR.
    run_op(3'd1, 4'd0, 8'h5A);
    run_op(3'd2, 4'd0, 8'h00);
    check("sh0_q", q, 8'h5A);
    check("sh0_done", {7'd0, done}, 8'd1);
    check("sh0_busy", {7'd0, busy}, 8'd0);
    run_op(3'd7, 4'd0, 8'h00);
    check("clear_q", q, 8'h00);

    // Start held high: a new op is accepted in the same cycle done is shown.
    start = 1'b1; mode = 3'd1; par_in = 8'h11; tick();
    mode = 3'd4; shamt = 4'd1; tick();
    check("b2b_busy", {7'd0, busy}, 8'd1);
    tick(); check("b2b_q", q, 8'h22);
    tick(); check("b2b_again", {7'd0, busy}, 8'd1);
    start = 1'b0; tick(); tick();

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      start      = 1'($urandom);
      mode       = 3'($urandom);
      shamt      = 4'($urandom_range(0, 12));
      par_in     = 8'($urandom);
      ser_in_lsb = 1'($urandom);
      ser_in_msb = 1'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
